// File: rtl/neopix_tx_encoder_if.sv
// Byte-stream handshake between the SPI receive slave (master side) and the
// WS2812 transmit encoder (slave side), plus the SPI frame-close pulse.
interface neopix_tx_encoder_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_end;

    modport master (
        output byte_data,
        output byte_valid,
        output frame_end,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  frame_end,
        output byte_ready
    );
endinterface

// File: rtl/neopix_tx_encoder.sv
// WS2812 serialiser: one-entry byte buffer, MSB-first bit timing, latch low time.
// Build option NEOPIX_TX_PAD_EN: short frames are padded with 0x00 bytes before latching.
module neopix_tx_encoder #(
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int RESET_CYCLES = 2500,
    parameter int NUM_LEDS     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    neopix_tx_encoder_if.slave    bus,
    output logic                  dout,
    output logic                  busy
);
    localparam int FRAME_BYTES = NUM_LEDS * 3;
    localparam int COUNT_W     = $clog2(FRAME_BYTES + 1);
    localparam int PHASE_MAX   = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int PHASE_W     = $clog2(PHASE_MAX);

    localparam logic [PHASE_W-1:0] BIT_LAST   = PHASE_W'(BIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] T0H_LAST   = PHASE_W'(T0H_CYCLES - 1);
    localparam logic [PHASE_W-1:0] T1H_LAST   = PHASE_W'(T1H_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RESET_LAST = PHASE_W'(RESET_CYCLES - 1);
    localparam logic [COUNT_W-1:0] FRAME_FULL = COUNT_W'(FRAME_BYTES);

`ifdef NEOPIX_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES && RESET_CYCLES > 0))
    begin : g_bad_timing
        $error("neopix_tx_encoder: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES > 0");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIGH  = 3'd1,
        LOW   = 3'd2,
        WAIT  = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;
    logic [2:0]           bit_reg, bit_next;
    logic [7:0]           shift_reg, shift_next;
    logic [COUNT_W-1:0]   count_reg, count_next;
    logic [7:0]           hold_data_reg, hold_data_next;
    logic                 hold_full_reg, hold_full_next;
    logic                 hold_late_reg, hold_late_next;
    logic                 end_pending_reg, end_pending_next;
    logic                 dout_reg;

    logic                 accept;
    logic                 drop;
    logic                 hold_ready;
    logic                 frame_done;
    logic                 pad_now;
    logic                 load_hold;
    logic                 load_zero;
    logic                 latch_entry;
    logic [PHASE_W-1:0]   high_last;

    // A byte accepted while a frame_end is already pending belongs to the next frame.
    assign accept     = bus.byte_valid && !hold_full_reg;
    assign drop       = (count_reg == FRAME_FULL) && !end_pending_reg;
    assign hold_ready = hold_full_reg && !hold_late_reg;
    assign frame_done = (count_reg == FRAME_FULL);
    assign pad_now    = PAD_EN && end_pending_reg && !frame_done;
    assign high_last  = shift_reg[7] ? T1H_LAST : T0H_LAST;

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
        load_hold   = 1'b0;
        load_zero   = 1'b0;
        latch_entry = 1'b0;

        case (state_reg)
            IDLE: begin
                if (hold_full_reg) begin
                    load_hold = 1'b1;
                end
            end
            HIGH: begin
                phase_next = phase_reg + 1'b1;
                if (phase_reg == high_last) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_reg != BIT_LAST) begin
                    phase_next = phase_reg + 1'b1;
                end else if (bit_reg != 3'd7) begin
                    phase_next = '0;
                    bit_next   = bit_reg + 3'd1;
                    shift_next = {shift_reg[6:0], 1'b0};
                    state_next = HIGH;
                end else if (frame_done) begin
                    latch_entry = 1'b1;
                end else if (hold_ready) begin
                    load_hold = 1'b1;
                end else if (pad_now) begin
                    load_zero = 1'b1;
                end else if (end_pending_reg) begin
                    latch_entry = 1'b1;
                end else begin
                    phase_next = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (hold_ready) begin
                    load_hold = 1'b1;
                end else if (pad_now) begin
                    load_zero = 1'b1;
                end else if (end_pending_reg) begin
                    latch_entry = 1'b1;
                end
            end
            LATCH: begin
                if (phase_reg == RESET_LAST) begin
                    phase_next = '0;
                    state_next = IDLE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: begin
                phase_next = '0;
                state_next = IDLE;
            end
        endcase

        if (load_hold || load_zero) begin
            shift_next = load_hold ? hold_data_reg : 8'h00;
            bit_next   = 3'd0;
            phase_next = '0;
            count_next = count_reg + 1'b1;
            state_next = HIGH;
        end
        if (latch_entry) begin
            phase_next = '0;
            count_next = '0;
            state_next = LATCH;
        end
    end

    // Holding register and frame-end bookkeeping.
    always_comb begin
        hold_data_next   = hold_data_reg;
        hold_full_next   = hold_full_reg;
        hold_late_next   = hold_late_reg;
        end_pending_next = end_pending_reg;

        if (load_hold) begin
            hold_full_next = 1'b0;
            hold_late_next = 1'b0;
        end else if (accept && !drop) begin
            hold_full_next = 1'b1;
            hold_data_next = bus.byte_data;
            hold_late_next = end_pending_reg;
        end

        // An empty, idle encoder has no frame for frame_end to close.
        if (bus.frame_end && (count_reg != '0 || hold_full_reg || accept)) begin
            end_pending_next = 1'b1;
        end
        if (latch_entry) begin
            end_pending_next = 1'b0;
            hold_late_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            bit_reg         <= 3'd0;
            shift_reg       <= 8'h00;
            count_reg       <= '0;
            hold_data_reg   <= 8'h00;
            hold_full_reg   <= 1'b0;
            hold_late_reg   <= 1'b0;
            end_pending_reg <= 1'b0;
            dout_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            bit_reg         <= bit_next;
            shift_reg       <= shift_next;
            count_reg       <= count_next;
            hold_data_reg   <= hold_data_next;
            hold_full_reg   <= hold_full_next;
            hold_late_reg   <= hold_late_next;
            end_pending_reg <= end_pending_next;
            dout_reg        <= (state_next == HIGH);
        end
    end

    // dout comes straight from a flop so the LED line never sees decode glitches.
    assign dout           = dout_reg;
    assign busy           = (state_reg != IDLE);
    assign bus.byte_ready = !hold_full_reg;

endmodule

// File: tb/tb_neopix_tx_encoder.sv
// Bench for neopix_tx_encoder: frame table plus hand sequences, with a dout
// decoder that pops expected bytes from a scoreboard queue.
module tb_neopix_tx_encoder;
    localparam int BIT_C   = 10;
    localparam int T0H_C   = 3;
    localparam int T1H_C   = 6;
    localparam int RESET_C = 20;
    localparam int NUM_L   = 2;

`ifdef NEOPIX_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic dout;
    logic busy;

    neopix_tx_encoder_if bus();

    neopix_tx_encoder #(
        .BIT_CYCLES  (BIT_C),
        .T0H_CYCLES  (T0H_C),
        .T1H_CYCLES  (T1H_C),
        .RESET_CYCLES(RESET_C),
        .NUM_LEDS    (NUM_L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dout(dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // data: byte i of the frame sits in data[i] (byte 0 is the rightmost in the literal)
    typedef struct {
        int               n_in;
        logic [7:0][7:0]  data;
        int               fend;     // 0 none, 1 pulse after last byte, 2 with last byte
        int               exp_tx;
        int               exp_pad;
    } frame_vec_t;

    frame_vec_t vecs [6];

    logic [7:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int n_latch = 0;
    int frame_bits = 0;
    bit contig = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic monitor();
        logic       prev_d = 1'b0;
        logic       prev_b = 1'b0;
        int         high = 0;
        int         since_rise = 0;
        int         low_run = 0;
        int         last_high = 0;
        logic [7:0] cur = 8'h00;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_d = 1'b0; prev_b = 1'b0; high = 0; since_rise = 0;
                low_run = 0; cur = 8'h00; frame_bits = 0;
                exp_q.delete();
                continue;
            end
            if (prev_b && !busy) begin
                n_vec++;
                if (low_run != BIT_C - last_high + RESET_C) begin
                    n_err++;
                    $display("FAIL latch_low: got %0d low cycles want %0d", low_run, BIT_C - last_high + RESET_C);
                end
                frame_bits = 0;
                n_latch++;
            end
            if (dout && !prev_d) begin
                if (contig && frame_bits > 0) begin
                    n_vec++;
                    if (since_rise != BIT_C) begin
                        n_err++;
                        $display("FAIL bit_period: got %0d cycles want %0d (bit %0d)", since_rise, BIT_C, frame_bits);
                    end
                end
                since_rise = 0;
                high = 0;
            end
            if (dout) begin
                high++;
            end else begin
                if (prev_d) begin
                    n_vec++;
                    if (high == T1H_C) cur = {cur[6:0], 1'b1};
                    else if (high == T0H_C) cur = {cur[6:0], 1'b0};
                    else begin
                        n_err++;
                        cur = {cur[6:0], 1'b0};
                        $display("FAIL high_len: got %0d cycles want %0d or %0d", high, T0H_C, T1H_C);
                    end
                    last_high = high;
                    low_run = 0;
                    frame_bits++;
                    if (frame_bits % 8 == 0) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL byte_unexpected: got %02h want none", cur);
                        end else begin
                            want = exp_q.pop_front();
                            if (cur !== want) begin
                                n_err++;
                                $display("FAIL byte: got %02h want %02h", cur, want);
                            end
                        end
                    end
                end
                low_run++;
            end
            since_rise++;
            prev_d = dout;
            prev_b = busy;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic fe);
        int g = 0;
        while (!bus.byte_ready && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.byte_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: got byte_ready=0 want 1");
        end
        bus.byte_data  = d;
        bus.byte_valid = 1'b1;
        bus.frame_end  = fe;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        bus.frame_end  = 1'b0;
    endtask

    task automatic pulse_fend();
        bus.frame_end = 1'b1;
        @(posedge clk); #1;
        bus.frame_end = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input int lat0);
        int g = 0;
        while (!(exp_q.size() == 0 && !busy) && g < 4000) begin
            @(negedge clk); #1;
            g++;
        end
        if (g >= 4000) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got %0d bytes outstanding busy=%0b want 0 and 0", name, exp_q.size(), busy);
        end
        repeat (3) @(negedge clk);
        check({name, "_latches"}, n_latch - lat0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        int lat0 = n_latch;
        for (int i = 0; i < v.n_in; i++) begin
            if (i < v.exp_tx) exp_q.push_back(v.data[i]);
            send_byte(v.data[i], (v.fend == 2) && (i == v.n_in - 1));
        end
        if (v.fend == 1) pulse_fend();
        for (int i = 0; i < v.exp_pad; i++) exp_q.push_back(8'h00);
        wait_frame_done($sformatf("frame%0d", idx), lat0);
    endtask

    initial begin
        int lat0;
        int g;

        vecs[0] = '{6, 64'h0000_0055_AA00_55AA, 0, 6, 0};
        vecs[1] = '{8, 64'h8877_6655_4433_2211, 1, 6, 0};
        vecs[2] = '{3, 64'h0000_0000_00AA_5500, 1, 3, PAD_ON ? 3 : 0};
        vecs[3] = '{6, 64'h0000_3CC3_7E01_80FF, 0, 6, 0};
        vecs[4] = '{1, 64'h0000_0000_0000_00F0, 2, 1, PAD_ON ? 5 : 0};
        vecs[5] = '{2, 64'h0000_0000_0000_A55A, 1, 2, PAD_ON ? 4 : 0};

        rst            = 1'b1;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_end  = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("reset_idle", {29'd0, dout, busy, bus.byte_ready}, 32'b001);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Stray frame_end while idle, then an underrun between two bytes.
        contig = 1'b0;
        lat0 = n_latch;
        pulse_fend();
        repeat (5) @(posedge clk); #1;
        check("stray_fend_busy", {31'd0, busy}, 0);
        exp_q.push_back(8'hC5);
        send_byte(8'hC5, 1'b0);
        repeat (121) @(posedge clk); #1;
        check("wait_state", {30'd0, busy, dout}, 32'b10);
        exp_q.push_back(8'h3A);
        send_byte(8'h3A, 1'b0);
        @(negedge clk);
        check("wait_no_early", {31'd0, dout}, 0);
        @(negedge clk);
        check("wait_resume", {31'd0, dout}, 1);
        @(posedge clk); #1;
        pulse_fend();
        for (int i = 0; i < (PAD_ON ? 4 : 0); i++) exp_q.push_back(8'h00);
        wait_frame_done("underrun", lat0);
        contig = 1'b1;

        // Asynchronous reset in bit 3 of byte 2.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        g = 0;
        while (!(frame_bits == 11 && dout) && g < 500) begin
            @(negedge clk); #1;
            g++;
        end
        check("reset_reach_bit", {31'd0, dout}, 1);
        #1 rst = 1'b1;
        #1;
        check("reset_async", {29'd0, dout, busy, bus.byte_ready}, 32'b001);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_frame(vecs[3], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/neopix_tx_encoder.md
# neopix_tx_encoder

Downstream stage of the SPI receive slave in the DE0 SPI-to-NeoPixel bridge. It accepts the received GRB byte stream over a valid/ready handshake and serialises it MSB-first onto one WS2812 data line (DO0/DO1), one instance per channel. At the end of each frame it emits the latch/reset low period. Frames end either on the byte count reaching NUM_LEDS×3 or on the SPI slave's frame-end pulse (SSEL deassertion).

## Interface
- BIT_CYCLES, 63: clocks per data bit (1.26 µs at 50 MHz)
- T0H_CYCLES, 20: high time of a 0 bit, in clocks
- T1H_CYCLES, 40: high time of a 1 bit, in clocks
- RESET_CYCLES, 2500: minimum low latch time after a frame, in clocks
- NUM_LEDS, 2: LEDs per frame; frame length is NUM_LEDS×3 bytes

- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-high reset
- byte_data  in  8  received byte (G, R, B order per LED)
- byte_valid  in  1  byte_data is valid
- byte_ready  out  1  holding register empty; a byte transfers on valid&&ready at the rising edge
- frame_end  in  1  one-cycle pulse; SPI frame closed
- dout  out  1  WS2812 serial data
- busy  out  1  high in any state other than IDLE

## Operation
- One-entry holding register (hold_data, hold_full) feeds an 8-bit shift register.
- byte_ready = !hold_full.
- States:
  - IDLE: dout=0.
  - HIGH: dout=1 for T0H/T1H cycles, selected by the current MSB.
  - LOW: dout=0 for the remainder of BIT_CYCLES.
  - WAIT: dout=0; bit budget exhausted, no byte available.
  - LATCH: dout=0 for RESET_CYCLES.
- IDLE→HIGH when hold_full. Load the shifter from the holding register and clear hold_full.
- HIGH→LOW after the high count. At the end of LOW:
  - Bits remain: shift left, go to HIGH.
  - Byte done and frame byte count = NUM_LEDS×3: go to LATCH.
  - Byte done and end pending: go to LATCH.
  - Byte done and hold_full: load the next byte, go to HIGH with no gap.
  - Otherwise: go to WAIT.
- WAIT→HIGH when hold_full. WAIT→LATCH when end pending.
- LATCH→IDLE after RESET_CYCLES. The byte counter clears on LATCH entry.
- The end-pending flag sets on frame_end and clears on LATCH entry. If frame_end arrives in IDLE with no bytes sent, the flag is ignored.
- Bytes accepted after the count reaches NUM_LEDS×3 and before frame_end are discarded: accepted and dropped.
- Bytes may be accepted during LATCH. They are sent after LATCH→IDLE.
- Byte counter width is clog2(NUM_LEDS×3+1). The bit counter is 3 bits. The phase counter is clog2(max(BIT_CYCLES, RESET_CYCLES)) bits.

## Timing
- Reset values:
  - dout=0, busy=0, byte_ready=1.
  - State IDLE; all counters, end-pending flag and hold_full cleared.
- Reset mid-frame forces dout low immediately (asynchronous). The partial frame is lost.
- Latency: a byte accepted at edge N in IDLE gives dout=1 in the cycle after edge N+1.
- Each bit is exactly BIT_CYCLES clocks. High time is exactly T0H_CYCLES or T1H_CYCLES.
- Back-to-back bytes carry no extra cycles, provided the next byte is held before the last LOW cycle of bit 0.
- frame_end coincident with a byte accept: the byte belongs to the current frame and is sent before LATCH.
- In WAIT, dout is low with no timeout. An underrun longer than about 50 µs is latched by the LEDs; that is acceptable behaviour.
- Parameter constraint: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES. The design must not be built with other values.

## Configuration
- NEOPIX_TX_PAD_EN defined: when end pending with fewer than NUM_LEDS×3 bytes sent, the encoder emits 0x00 bytes until the count is reached, then LATCH. Unlit LEDs therefore turn off.
- Undefined: a short frame goes straight to LATCH. The LEDs beyond the sent bytes retain their previous colour.

## Test plan
All scenarios use BIT_CYCLES=10, T0H=3, T1H=6, RESET_CYCLES=20, NUM_LEDS=2.
- Reset, no input → dout=0, busy=0, byte_ready=1 for 100 cycles.
- Bytes 0xAA,0x55,0x00,0xAA,0x55,0x00 streamed with valid held → 48 bits, each high 6/3 cycles matching the data, no gaps. dout stays low for 20 cycles. busy falls after LATCH.
- Eight bytes then frame_end → only the first 6 are transmitted; bytes 7 and 8 are accepted and dropped.
- 0x00,0x55,0xAA then frame_end (PAD_EN undefined) → 24 bits then LATCH. With PAD_EN → 24 more zero bits (high 3 cycles each), then LATCH.
- One byte, 40-cycle pause, second byte → WAIT entered, dout low throughout. The second byte starts a new bit on the cycle after hold_full.
- rst asserted during bit 3 of byte 2 → dout=0 asynchronously. After release, the next frame starts from byte count 0.
